// File: rtl/ascon_stream_fifo.sv
// rtl/ascon_stream_fifo.sv - parameterised valid/ready FIFO with optional fall-through and status flags
module ascon_stream_fifo #(
    parameter int DATA_WIDTH      = 64,
    parameter int DEPTH           = 4,
    parameter int FALL_THROUGH    = 0,
    parameter int ALMOST_FULL_TH  = DEPTH - 1,
    parameter int ALMOST_EMPTY_TH = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [DATA_WIDTH-1:0]        data_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic [$clog2(DEPTH+1)-1:0]   usage_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         almost_full_o,
    output logic                         almost_empty_o,
    output logic                         overflow_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int USE_W = $clog2(DEPTH + 1);

    localparam logic [USE_W-1:0] DEPTH_U   = USE_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [31:0]      AF_TH     = ALMOST_FULL_TH;
    localparam logic [31:0]      AE_TH     = ALMOST_EMPTY_TH;
    localparam bit               FT        = (FALL_THROUGH != 0);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [USE_W-1:0]      usage;
    logic                  overflow;

    logic bypass_sel;
    logic push;
    logic pop;
    logic wr_en;
    logic rd_en;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Status is decoded purely from the registered count, so ready_o never sees ready_i.
    assign usage_o        = usage;
    assign full_o         = (usage == DEPTH_U);
    assign empty_o        = (usage == '0);
    assign almost_full_o  = (32'(usage) >= AF_TH);
    assign almost_empty_o = (32'(usage) <= AE_TH);
    assign ready_o        = !full_o;
    assign overflow_o     = overflow;

    // When empty in fall-through mode the input is presented directly at the output.
    assign bypass_sel = FT && empty_o;
    assign valid_o    = bypass_sel ? valid_i : !empty_o;
    assign data_o     = bypass_sel ? data_i : (empty_o ? '0 : mem[rd_ptr]);

    // A bypassed word taken by the consumer in the same cycle never touches storage.
    assign push  = valid_i && ready_o;
    assign pop   = valid_o && ready_i;
    assign wr_en = push && !(bypass_sel && ready_i);
    assign rd_en = pop && !empty_o;

    // Pointer and occupancy bookkeeping; flush overrides any same-cycle transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usage  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usage  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({wr_en, rd_en})
                2'b10:   usage <= usage + USE_W'(1);
                2'b01:   usage <= usage - USE_W'(1);
                default: usage <= usage;
            endcase
        end
    end

    // Sticky record of a producer offering data while the FIFO was full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (flush_i) begin
            overflow <= 1'b0;
        end else if (valid_i && !ready_o) begin
            overflow <= 1'b1;
        end
    end

    // Payload storage is left unreset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en && !flush_i) begin
            mem[wr_ptr] <= data_i;
        end
    end

endmodule

// File: tb/tb_ascon_stream_fifo.sv
// tb/tb_ascon_stream_fifo.sv - directed self-checking bench for ascon_stream_fifo
module tb_ascon_stream_fifo;

    logic        clk = 1'b0;
    logic        rst;

    logic        flush_i, valid_i, ready_i;
    logic [63:0] data_i;
    logic        ready_o, valid_o, full_o, empty_o, almost_full_o, almost_empty_o, overflow_o;
    logic [63:0] data_o;
    logic [1:0]  usage_o;

    logic        ft_flush_i, ft_valid_i, ft_ready_i;
    logic [63:0] ft_data_i;
    logic        ft_ready_o, ft_valid_o, ft_full_o, ft_empty_o, ft_almost_full_o, ft_almost_empty_o, ft_overflow_o;
    logic [63:0] ft_data_o;
    logic [1:0]  ft_usage_o;

    int total = 0;
    int bad   = 0;

    logic [63:0] q[$];

    always #5 clk = ~clk;

    ascon_stream_fifo #(.DATA_WIDTH(64), .DEPTH(3), .FALL_THROUGH(0)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .usage_o(usage_o), .full_o(full_o), .empty_o(empty_o),
        .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
        .overflow_o(overflow_o)
    );

    ascon_stream_fifo #(.DATA_WIDTH(64), .DEPTH(3), .FALL_THROUGH(1)) dut_ft (
        .clk(clk), .rst(rst), .flush_i(ft_flush_i),
        .valid_i(ft_valid_i), .ready_o(ft_ready_o), .data_i(ft_data_i),
        .valid_o(ft_valid_o), .ready_i(ft_ready_i), .data_o(ft_data_o),
        .usage_o(ft_usage_o), .full_o(ft_full_o), .empty_o(ft_empty_o),
        .almost_full_o(ft_almost_full_o), .almost_empty_o(ft_almost_empty_o),
        .overflow_o(ft_overflow_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_levels(input string tag, input int u);
        check({tag, " usage"}, 64'(usage_o), 64'(u));
        check({tag, " full"}, 64'(full_o), 64'(u == 3));
        check({tag, " empty"}, 64'(empty_o), 64'(u == 0));
        check({tag, " afull"}, 64'(almost_full_o), 64'(u >= 2));
        check({tag, " aempty"}, 64'(almost_empty_o), 64'(u <= 1));
        check({tag, " ready"}, 64'(ready_o), 64'(u != 3));
    endtask

    initial begin
        rst = 1'b1;
        flush_i = 0; valid_i = 0; ready_i = 0; data_i = '0;
        ft_flush_i = 0; ft_valid_i = 1; ft_ready_i = 0; ft_data_i = 64'h33;

        // reset state
        #3;
        check_levels("rst", 0);
        check("rst valid_o", 64'(valid_o), 64'd0);
        check("rst data_o", data_o, 64'd0);
        check("rst overflow", 64'(overflow_o), 64'd0);
        check("rst ft valid_o", 64'(ft_valid_o), 64'd1);
        check("rst ft data_o", ft_data_o, 64'h33);
        ft_valid_i = 0;
        #10;
        rst = 1'b0;
        cyc();

        // fill to full with consumer stalled, then overflow attempt
        valid_i = 1; ready_i = 0;
        for (int i = 0; i < 3; i++) begin
            data_i = 64'hA + 64'(i);
            cyc();
            check_levels($sformatf("fill%0d", i + 1), i + 1);
        end
        check("full valid_o", 64'(valid_o), 64'd1);
        check("full head", data_o, 64'hA);
        check("no overflow yet", 64'(overflow_o), 64'd0);
        data_i = 64'hF;
        cyc();
        valid_i = 0;
        check("overflow set", 64'(overflow_o), 64'd1);
        check_levels("after ovf", 3);

        // pop once, then sustained push+pop across pointer wrap
        ready_i = 1;
        #1;
        check("pop head A", data_o, 64'hA);
        cyc();
        check_levels("after pop", 2);
        q = '{64'hB, 64'hC};
        for (int i = 0; i < 10; i++) begin
            valid_i = 1;
            data_i  = 64'h100 + 64'(i);
            #1;
            check($sformatf("stream%0d data", i), data_o, q[0]);
            cyc();
            void'(q.pop_front());
            q.push_back(64'h100 + 64'(i));
            check($sformatf("stream%0d usage", i), 64'(usage_o), 64'd2);
        end

        // drain, checking threshold flags on the way down
        valid_i = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("drain%0d data", i), data_o, q[0]);
            cyc();
            void'(q.pop_front());
            check_levels($sformatf("drain%0d", i), 1 - i);
        end
        check("drained valid_o", 64'(valid_o), 64'd0);
        check("drained data_o", data_o, 64'd0);
        check("overflow sticky", 64'(overflow_o), 64'd1);
        ready_i = 0;

        // flush beats a same-cycle push and pop
        valid_i = 1;
        data_i = 64'h21; cyc();
        data_i = 64'h22; cyc();
        check_levels("pre flush", 2);
        flush_i = 1; data_i = 64'hD; ready_i = 1;
        cyc();
        flush_i = 0; valid_i = 0; ready_i = 0;
        check_levels("post flush", 0);
        check("flush valid_o", 64'(valid_o), 64'd0);
        check("flush overflow", 64'(overflow_o), 64'd0);
        valid_i = 1; data_i = 64'h7;
        cyc();
        valid_i = 0;
        check("after flush head", data_o, 64'h7);
        check_levels("after flush push", 1);
        ready_i = 1;
        cyc();
        ready_i = 0;
        check_levels("emptied", 0);

        // asynchronous reset between edges
        valid_i = 1;
        data_i = 64'h31; cyc();
        data_i = 64'h32; cyc();
        valid_i = 0;
        check_levels("pre async rst", 2);
        #2;
        rst = 1'b1;
        #1;
        check_levels("async rst", 0);
        check("async rst valid_o", 64'(valid_o), 64'd0);
        check("async rst data_o", data_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        valid_i = 1; data_i = 64'h1;
        cyc();
        valid_i = 0;
        check("post rst head", data_o, 64'h1);
        check("post rst valid_o", 64'(valid_o), 64'd1);
        check_levels("post rst", 1);

        // fall-through bypass with consumer ready
        ft_valid_i = 1; ft_data_i = 64'h55; ft_ready_i = 1;
        #1;
        check("ft bypass valid_o", 64'(ft_valid_o), 64'd1);
        check("ft bypass data_o", ft_data_o, 64'h55);
        cyc();
        check("ft bypass usage", 64'(ft_usage_o), 64'd0);
        check("ft bypass empty", 64'(ft_empty_o), 64'd1);

        // fall-through with consumer stalled stores the word
        ft_ready_i = 0;
        cyc();
        ft_valid_i = 0; ft_data_i = 64'h99;
        #1;
        check("ft store usage", 64'(ft_usage_o), 64'd1);
        check("ft store valid_o", 64'(ft_valid_o), 64'd1);
        check("ft store data_o", ft_data_o, 64'h55);
        ft_ready_i = 1;
        cyc();
        ft_ready_i = 0;
        check("ft pop usage", 64'(ft_usage_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
